// File: rtl/mux16x1_pkg.sv
// mux16x1_pkg: shared constants and select type for the registered 16:1 word mux
package mux16x1_pkg;
  localparam int N_IN = 16;
  localparam int SEL_W = 4;
  localparam int DEF_WIDTH = 32;
  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/mux16x1_comb.sv
// mux16x1_comb: purely combinational 16:1 word selector
module mux16x1_comb
  import mux16x1_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [N_IN-1:0][WIDTH-1:0] a,
  input  sel_t                       sel,
  output logic [WIDTH-1:0]           y
);
  assign y = a[sel];
endmodule

// File: rtl/mux16x1_reg.sv
// mux16x1_reg: registered 16:1 word mux with valid flag
// Optional out_parity output (even parity of out) when MUX16X1_REG_PARITY_EN is defined.
module mux16x1_reg
  import mux16x1_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  input  logic [WIDTH-1:0] a4,
  input  logic [WIDTH-1:0] a5,
  input  logic [WIDTH-1:0] a6,
  input  logic [WIDTH-1:0] a7,
  input  logic [WIDTH-1:0] a8,
  input  logic [WIDTH-1:0] a9,
  input  logic [WIDTH-1:0] a10,
  input  logic [WIDTH-1:0] a11,
  input  logic [WIDTH-1:0] a12,
  input  logic [WIDTH-1:0] a13,
  input  logic [WIDTH-1:0] a14,
  input  logic [WIDTH-1:0] a15,
  input  sel_t             sel,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
`ifdef MUX16X1_REG_PARITY_EN
  ,
  output logic             out_parity
`endif
);
  logic [N_IN-1:0][WIDTH-1:0] a_w;
  logic [WIDTH-1:0] y_w, out_d, out_q;
  logic valid_q;
  assign a_w = {a15, a14, a13, a12, a11, a10, a9, a8, a7, a6, a5, a4, a3, a2, a1, a0};
  mux16x1_comb #(.WIDTH(WIDTH)) u_comb (
    .a  (a_w),
    .sel(sel),
    .y  (y_w)
  );
  always_comb out_d = en ? y_w : out_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= en;
    end
  end
  assign out       = out_q;
  assign out_valid = valid_q;
`ifdef MUX16X1_REG_PARITY_EN
  logic par_d, par_q;
  always_comb par_d = en ? ^y_w : par_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end
  assign out_parity = par_q;
`endif
endmodule

// File: tb/tb_mux16x1_reg.sv
// tb_mux16x1_reg: table-driven and randomized self-checking bench for mux16x1_reg
module tb_mux16x1_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [31:0] a [16];
  logic [3:0] sel = '0;
  logic en = 1'b0;
  logic [31:0] out;
  logic out_valid;
  int errs = 0;
  int checks = 0;
  logic [31:0] exp_out;
  logic exp_valid;
  always #5 clk = ~clk;
`ifdef MUX16X1_REG_PARITY_EN
  logic out_parity;
`endif
  mux16x1_reg dut (
    .clk(clk), .rst_n(rst_n),
    .a0(a[0]), .a1(a[1]), .a2(a[2]), .a3(a[3]), .a4(a[4]), .a5(a[5]), .a6(a[6]), .a7(a[7]),
    .a8(a[8]), .a9(a[9]), .a10(a[10]), .a11(a[11]), .a12(a[12]), .a13(a[13]), .a14(a[14]), .a15(a[15]),
    .sel(sel), .en(en), .out(out), .out_valid(out_valid)
`ifdef MUX16X1_REG_PARITY_EN
    , .out_parity(out_parity)
`endif
  );
  typedef struct {
    logic [3:0]  sel;
    logic        en;
    logic [31:0] din;
    logic [31:0] exp_out;
    logic        exp_valid;
  } vec_t;
  vec_t vecs [7];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask
  task automatic chk_out(input string nm);
    chk({nm, ".out"}, out, exp_out);
    chk({nm, ".valid"}, {31'b0, out_valid}, {31'b0, exp_valid});
`ifdef MUX16X1_REG_PARITY_EN
    chk({nm, ".parity"}, {31'b0, out_parity}, {31'b0, ^exp_out});
`endif
  endtask
  // One clock: the reference model captures what the design should capture at this edge.
  task automatic step();
    logic [31:0] cap;
    logic cap_en;
    cap = a[sel];
    cap_en = en;
    @(posedge clk);
    if (cap_en) exp_out = cap;
    exp_valid = cap_en;
    #1;
  endtask
  initial begin
    for (int k = 0; k < 16; k++) a[k] = '0;
    a[1] = 32'd5;
    sel = 4'd1;
    en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    exp_out = '0;
    exp_valid = 1'b0;
    chk_out("reset_async");
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_out("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    for (int k = 0; k < 16; k++) a[k] = '0;
    vecs[0] = '{4'd2,  1'b1, 32'h1,   32'h1,   1'b1};
    vecs[1] = '{4'd1,  1'b1, 32'h5,   32'h5,   1'b1};
    vecs[2] = '{4'd15, 1'b1, 32'hAAA, 32'hAAA, 1'b1};
    vecs[3] = '{4'd3,  1'b0, 32'h0,   32'hAAA, 1'b0};
    vecs[4] = '{4'd15, 1'b0, 32'h0,   32'hAAA, 1'b0};
    vecs[5] = '{4'd0,  1'b1, 32'h7,   32'h7,   1'b1};
    vecs[6] = '{4'd4,  1'b1, 32'hAAA, 32'hAAA, 1'b1};
    for (int i = 0; i < 7; i++) begin
      sel = vecs[i].sel;
      en = vecs[i].en;
      a[vecs[i].sel] = vecs[i].din;
      step();
      chk($sformatf("vec%0d.out", i), out, vecs[i].exp_out);
      chk($sformatf("vec%0d.valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_valid});
`ifdef MUX16X1_REG_PARITY_EN
      chk($sformatf("vec%0d.parity", i), {31'b0, out_parity}, {31'b0, ^vecs[i].din & vecs[i].en | ^vecs[i].exp_out & ~vecs[i].en});
`endif
    end
    for (int k = 0; k < 16; k++) a[k] = 32'hA5A50000 + k;
    en = 1'b1;
    for (int s = 0; s < 16; s++) begin
      sel = s[3:0];
      step();
      chk($sformatf("sweep%0d", s), out, 32'hA5A50000 + s);
      chk($sformatf("sweep%0d.valid", s), {31'b0, out_valid}, 32'd1);
    end
    for (int k = 0; k < 16; k++) a[k] = 'x;
    a[9] = 32'h1234_5678;
    sel = 4'd9;
    step();
    chk_out("x_isolation");
    for (int k = 0; k < 16; k++) a[k] = $urandom;
    sel = 4'd6;
    step();
    a[6] = 32'hDEAD_BEEF;
    #2 rst_n = 1'b0;
    #1;
    exp_out = '0;
    exp_valid = 1'b0;
    chk_out("midreset_async");
    #1 rst_n = 1'b1;
    sel = 4'd6;
    step();
    chk("midreset_next", out, 32'hDEAD_BEEF);
    chk_out("midreset_model");
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 16; k++) a[k] = $urandom;
      sel = 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 3) != 0);
      step();
      chk_out($sformatf("rand%0d", i));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
